sel_bits: RTL and testbench
===========================

# sel_bits

Iterative bit selector: the inverse of bit counting. Given a request vector and a count K, it returns a mask of the K lowest-indexed active bits, plus the number actually selected. Typical use is allocating K free entries from a free-list vector in issue queues, reorder buffers and similar structures. It scans CHUNK bits per cycle behind valid/ready handshakes on both sides.

## Interface
- IN, 128, request vector width
- ACT, `High, active level of request bits (from stddef.vh)
- CHUNK, 16, bits examined per scan cycle
- CNT, $clog2(IN)+1, count width (derived; not overridden)
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted this cycle if req_valid
- req_vec  in  IN  candidate bits; a bit is active when equal to ACT
- req_cnt  in  CNT  number of bits wanted
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_mask  out  IN  selected bits, 1 = selected (always active-high)
- out_cnt  out  CNT  number of bits selected
- out_short  out  1  out_cnt < saturated req_cnt

## Operation
- NCH = ceil(IN/CHUNK). When IN is not a multiple of CHUNK, pad positions are inactive.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_vec and want = min(req_cnt, IN). Clear the mask, pointer and selected count. Go to SCAN.
  - SCAN: process chunk[ptr]. Select the lowest active bits of the chunk, up to rem = want - selected. OR them into the mask and add them to selected. Then ptr++.
  - SCAN exit: go to DONE when rem reaches 0 (early exit, see Configuration) or when ptr == NCH-1 was just processed.
  - DONE: out_valid=1. Outputs are stable until out_ready. On handshake go to IDLE.
- No bit outside req_vec's active set is ever selected. Selection is strictly ascending index.
- req_cnt = 0 gives out_mask = 0, out_cnt = 0, out_short = 0.
- req_cnt > IN is saturated to IN before use. out_short compares against the saturated value.
- Reset at any time, including mid-SCAN or in DONE: the request is aborted with no output.
  - Next state IDLE.
  - Reset values: out_valid=0, out_mask=0, out_cnt=0, out_short=0, req_ready=1.

## Timing
- Accept at cycle T. Chunk i is processed at cycle T+1+i. out_valid rises at T+n+1, where n = chunks processed (1..NCH).
- Worst-case latency is NCH+1 cycles from accept to out_valid.
- req_ready is low from T+1 until the cycle after the output handshake. Throughput is one request per (n+2) cycles minimum.
- req_ready and out_valid are decoded from the state register only; there are no combinational paths from inputs.
- out_valid held with out_ready=0: out_mask, out_cnt and out_short must not change.

## Configuration
- SEL_BITS_EARLY_EXIT_EN
  - Defined: SCAN leaves as soon as rem reaches 0, so n = index of the chunk satisfying the request + 1. For req_cnt=0, n=1.
  - Undefined: all NCH chunks are always scanned, giving a fixed latency of NCH+1. Results are identical.

## Structure
- Shared package sel_bits_pkg holds:
  - the FSM state enum (IDLE, SCAN, DONE)
  - the NCH computation as a function of IN and CHUNK
- Sub-module chunk_sel:
  - Combinational. Inputs: CHUNK-bit active vector and a remaining count.
  - Outputs: CHUNK-bit selection mask and its popcount, built as a prefix count over the chunk.
  - Instantiated once; the chunk is muxed by ptr.
- The registered datapath (latched vector, mask, selected count, ptr) stays in sel_bits.

## Test plan
Bench uses IN=16, CHUNK=4 (NCH=4) and ACT=`High unless noted.
- vec 16'hFFFF, cnt 3 -> mask 16'h0007, cnt 3, short 0. out_valid at T+2 with EARLY_EXIT_EN, T+5 without.
- vec 16'h8421, cnt 3 -> mask 16'h0421, cnt 3, short 0. out_valid at T+4 with EARLY_EXIT_EN.
- vec 16'h0101, cnt 5 -> mask 16'h0101, cnt 2, short 1, out_valid at T+5. With ACT=`Low, vec 16'hFEFE, cnt 5 gives the same result.
- vec 16'hFFFF, cnt 17 (saturates to 16) -> mask 16'hFFFF, cnt 16, short 0. Separately, cnt 0 -> mask 0, cnt 0, short 0.
- Hold out_ready low 3 cycles in DONE -> outputs stable and req_ready=0 throughout. Then out_ready=1 -> req_ready=1 the next cycle, and a back-to-back request is accepted.
- Assert reset at T+2 during SCAN of vec 16'hF0F0, cnt 6 -> out_valid=0, all outputs 0, req_ready=1. A new request then completes correctly.

Source files
------------

// File: rtl/sel_bits_pkg.sv
// Shared types and helpers for the sel_bits iterative bit selector.
package sel_bits_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam bit ACT_HIGH = 1'b1;
  localparam bit ACT_LOW  = 1'b0;

  // Number of CHUNK-wide scan steps needed to cover an IN-bit vector.
  function automatic int nch_f(input int in_w, input int chunk_w);
    return (in_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/sel_bits_chunk_sel.sv
// Combinational selector: picks the lowest active bits of one chunk, at most rem_i of them,
// using a running prefix count across the chunk.
module sel_bits_chunk_sel #(
  parameter int CHUNK = 16,
  parameter int CNT   = 8
) (
  input  logic [CHUNK-1:0] act_i,
  input  logic [CNT-1:0]   rem_i,
  output logic [CHUNK-1:0] sel_o,
  output logic [CNT-1:0]   cnt_o
);

  always_comb begin
    logic [CNT-1:0] run;
    run   = '0;
    sel_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (act_i[i] && (run < rem_i)) begin
        sel_o[i] = 1'b1;
        run      = run + CNT'(1);
      end
    end
    cnt_o = run;
  end

endmodule

// File: rtl/sel_bits.sv
// Iterative bit selector: returns a mask of the req_cnt lowest-indexed active bits of req_vec,
// scanning CHUNK bits per cycle. Define SEL_BITS_EARLY_EXIT_EN to stop scanning once satisfied.
module sel_bits
  import sel_bits_pkg::*;
#(
  parameter int  IN    = 128,
  parameter bit  ACT   = ACT_HIGH,
  parameter int  CHUNK = 16,
  localparam int CNT   = $clog2(IN) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [IN-1:0] req_vec,
  input  logic [CNT-1:0] req_cnt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IN-1:0] out_mask,
  output logic [CNT-1:0] out_cnt,
  output logic          out_short
);

  localparam int NCH   = nch_f(IN, CHUNK);
  localparam int PADW  = NCH * CHUNK;
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_q, state_d;
  logic [PADW-1:0]  act_q;
  logic [IN-1:0]    req_act;
  logic [IN-1:0]    mask_q, mask_d;
  logic [CNT-1:0]   want_q, want_d;
  logic [CNT-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CHUNK-1:0] chunk_act, chunk_sel;
  logic [CNT-1:0]   chunk_cnt, rem;
  logic [PADW-1:0]  chunk_shift;
  logic             last_chunk;

  function automatic logic [CNT-1:0] sat_cnt(input logic [CNT-1:0] c);
    return (c > CNT'(IN)) ? CNT'(IN) : c;
  endfunction

  // Latched vector is normalised to active-high; pad positions stay zero (inactive).
  assign req_act     = ACT ? req_vec : ~req_vec;
  assign chunk_act   = act_q[ptr_q*CHUNK +: CHUNK];
  assign rem         = want_q - sel_q;
  assign chunk_shift = PADW'(chunk_sel) << (ptr_q * CHUNK);
  assign last_chunk  = (ptr_q == PTR_W'(NCH - 1));

  sel_bits_chunk_sel #(
    .CHUNK (CHUNK),
    .CNT   (CNT)
  ) u_chunk_sel (
    .act_i (chunk_act),
    .rem_i (rem),
    .sel_o (chunk_sel),
    .cnt_o (chunk_cnt)
  );

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) act_q <= PADW'(req_act);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    want_d  = want_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          want_d  = sat_cnt(req_cnt);
          mask_d  = '0;
          sel_d   = '0;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        mask_d = mask_q | chunk_shift[IN-1:0];
        sel_d  = sel_q + chunk_cnt;
        ptr_d  = ptr_q + PTR_W'(1);
`ifdef SEL_BITS_EARLY_EXIT_EN
        if (last_chunk || (chunk_cnt == rem)) state_d = DONE;
`else
        if (last_chunk) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      want_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      want_q  <= want_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_mask  = mask_q;
  assign out_cnt   = sel_q;
  assign out_short = (sel_q < want_q);

endmodule

// File: tb/tb_sel_bits.sv
// Self-checking bench for sel_bits (IN=16, CHUNK=4): vector table, hold/back-to-back,
// mid-scan reset and randomized requests against a reference model; an ACT=Low copy sees ~vec.
module tb_sel_bits;
  import sel_bits_pkg::*;

  localparam int IN = 16, CHUNK = 4, NCH = 4, CNT = 5;
`ifdef SEL_BITS_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, req_valid, out_ready;
  logic [IN-1:0]  req_vec, req_vec_lo;
  logic [CNT-1:0] req_cnt;
  logic           req_ready, out_valid, out_short;
  logic [IN-1:0]  out_mask;
  logic [CNT-1:0] out_cnt;
  logic           lo_req_ready, lo_out_valid, lo_out_short;
  logic [IN-1:0]  lo_out_mask;
  logic [CNT-1:0] lo_out_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign req_vec_lo = ~req_vec;

  sel_bits #(.IN(IN), .ACT(ACT_HIGH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .req_cnt(req_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_cnt(out_cnt), .out_short(out_short));

  sel_bits #(.IN(IN), .ACT(ACT_LOW), .CHUNK(CHUNK)) dut_lo (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(lo_req_ready),
    .req_vec(req_vec_lo), .req_cnt(req_cnt), .out_valid(lo_out_valid), .out_ready(out_ready),
    .out_mask(lo_out_mask), .out_cnt(lo_out_cnt), .out_short(lo_out_short));

  typedef struct {
    logic [IN-1:0]  vec;
    logic [CNT-1:0] cnt;
    logic [IN-1:0]  mask;
    logic [CNT-1:0] ocnt;
    bit             short_;
    int             lat_ee;
    int             hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk bits in ascending order taking active ones until the saturated count is met.
  function automatic void model(input logic [IN-1:0] vec, input logic [CNT-1:0] cnt,
                                output logic [IN-1:0] m, output logic [CNT-1:0] n,
                                output bit s, output int lat);
    int want, got;
    want = (int'(cnt) > IN) ? IN : int'(cnt);
    got  = 0;
    m    = '0;
    lat  = NCH;
    if (want == 0) lat = 1;
    for (int i = 0; i < IN; i++) begin
      if (vec[i] && got < want) begin
        m[i] = 1'b1;
        got++;
        if (got == want) lat = i / CHUNK + 1;
      end
    end
    n = CNT'(got);
    s = (got < want);
    if (!EE) lat = NCH;
  endfunction

  // Caller is positioned just after a rising edge.
  task automatic run_req(input logic [IN-1:0] vec, input logic [CNT-1:0] cnt,
                         input logic [IN-1:0] em, input logic [CNT-1:0] ec, input bit es,
                         input int elat, input int hold);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_vec = vec; req_cnt = cnt; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid && k < 40);
    chk("latency", k, elat);
    chk("out_valid", out_valid, 1);
    chk("out_mask", out_mask, em);
    chk("out_cnt", out_cnt, ec);
    chk("out_short", out_short, es);
    chk("lo_out_mask", lo_out_mask, em);
    chk("lo_out_cnt", lo_out_cnt, ec);
    chk("lo_out_short", lo_out_short, es);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", req_ready, 0);
      chk("hold_mask", out_mask, em);
      chk("hold_cnt", out_cnt, ec);
      chk("hold_short", out_short, es);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_hs", req_ready, 1);
    chk("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    logic [IN-1:0]  m;
    logic [CNT-1:0] n, c;
    logic [IN-1:0]  v;
    bit             s;
    int             lat;

    tbl[0] = '{16'hFFFF, 5'd3,  16'h0007, 5'd3,  1'b0, 1, 3};
    tbl[1] = '{16'h8421, 5'd3,  16'h0421, 5'd3,  1'b0, 3, 0};
    tbl[2] = '{16'h0101, 5'd5,  16'h0101, 5'd2,  1'b1, 4, 0};
    tbl[3] = '{16'hFFFF, 5'd17, 16'hFFFF, 5'd16, 1'b0, 4, 0};
    tbl[4] = '{16'hFFFF, 5'd0,  16'h0000, 5'd0,  1'b0, 1, 0};
    tbl[5] = '{16'hF0F0, 5'd6,  16'h30F0, 5'd6,  1'b0, 4, 0};

    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0; req_vec = '0; req_cnt = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_short", out_short, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_req(tbl[i].vec, tbl[i].cnt, tbl[i].mask, tbl[i].ocnt, tbl[i].short_,
              EE ? tbl[i].lat_ee : NCH, tbl[i].hold);

    // Reset during SCAN aborts the request with no output.
    req_vec = 16'hF0F0; req_cnt = 5'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_mask", out_mask, 0);
    chk("abort_out_cnt", out_cnt, 0);
    chk("abort_out_short", out_short, 0);
    chk("abort_req_ready", req_ready, 1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_output", out_valid, 0);
    run_req(tbl[5].vec, tbl[5].cnt, tbl[5].mask, tbl[5].ocnt, tbl[5].short_,
            EE ? tbl[5].lat_ee : NCH, 0);

    for (int r = 0; r < 40; r++) begin
      v = (r % 2 == 0) ? IN'($urandom) : IN'($urandom & $urandom & $urandom);
      c = CNT'($urandom_range(0, 20));
      model(v, c, m, n, s, lat);
      run_req(v, c, m, n, s, lat, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
